// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the two-requester ALU arbiter:
//   - alu_op_e    : 4-bit ALU opcode encoding
//   - arb_state_e : arbiter FSM state encoding (IDLE, EXEC, RESP)
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_ADD1 = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SUB1 = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NAND = 4'b0111,
    ALU_SHL1 = 4'b1000,
    ALU_SHL2 = 4'b1001,
    ALU_SHL3 = 4'b1010,
    ALU_SHL4 = 4'b1011,
    ALU_SHR1 = 4'b1100,
    ALU_SHR2 = 4'b1101,
    ALU_SHR3 = 4'b1110,
    ALU_SHR4 = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
//   Combinational signed ALU shared by the arbiter.
//   Ports:
//     opcode      in  4      operation (alu_op_e encoding)
//     op1, op2    in  WIDTH  signed operands
//     result      out WIDTH  signed result, truncated to WIDTH
//     equals_zero out 1      result is all zeros
//     overflow    out 1      signed overflow of ADD/ADD1/SUB/SUB1, else 0
//   ADD1/SUB1 are op1+1 / op1-1; SHLn/SHRn shift op1 by n (SHR is logical).
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]              opcode,
  input  logic signed [WIDTH-1:0] op1,
  input  logic signed [WIDTH-1:0] op2,
  output logic signed [WIDTH-1:0] result,
  output logic                    equals_zero,
  output logic                    overflow
);

  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [WIDTH-1:0] rhs_s;
  logic signed [WIDTH-1:0] add_s;
  logic signed [WIDTH-1:0] sub_s;
  logic [2:0]              shamt_s;

  // The increment/decrement opcodes reuse the adder with a constant one.
  assign rhs_s   = ((opcode == ALU_ADD1) || (opcode == ALU_SUB1)) ? ONE : op2;
  assign add_s   = op1 + rhs_s;
  assign sub_s   = op1 - rhs_s;
  assign shamt_s = {1'b0, opcode[1:0]} + 3'd1;

  // Operation select and signed overflow detection.
  always_comb begin
    result   = {WIDTH{1'b0}};
    overflow = 1'b0;
    case (opcode)
      ALU_ADD, ALU_ADD1: begin
        result   = add_s;
        overflow = (op1[WIDTH-1] == rhs_s[WIDTH-1]) && (add_s[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_SUB, ALU_SUB1: begin
        result   = sub_s;
        overflow = (op1[WIDTH-1] != rhs_s[WIDTH-1]) && (sub_s[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_NAND: result = ~(op1 & op2);
      ALU_SHL1, ALU_SHL2, ALU_SHL3, ALU_SHL4: result = op1 << shamt_s;
      ALU_SHR1, ALU_SHR2, ALU_SHR3, ALU_SHR4: result = op1 >> shamt_s;
      default: begin
        result   = {WIDTH{1'b0}};
        overflow = 1'b0;
      end
    endcase
  end

  assign equals_zero = (result == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one ALU between two requesters with round-robin arbitration and a
//   three-state FSM (IDLE -> EXEC -> RESP). One operation per three cycles.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     reqN_valid/ready           request handshake for requester N (0, 1)
//     reqN_opcode/op1/op2        request payload
//     rsp_valid/ready            response handshake, rsp_* held until taken
//     rsp_id                     requester owning the response
//     rsp_result/zero/ovf        registered ALU outputs
//   Optional (macro ALU_ARB_STICKY_OVF_EN):
//     ovf_clr     in  1  clears ovf_sticky (a same-edge set wins)
//     ovf_sticky  out 2  bit N set by an overflowing response to requester N
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [3:0]              req0_opcode,
  input  logic signed [WIDTH-1:0] req0_op1,
  input  logic signed [WIDTH-1:0] req0_op2,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [3:0]              req1_opcode,
  input  logic signed [WIDTH-1:0] req1_op1,
  input  logic signed [WIDTH-1:0] req1_op2,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic signed [WIDTH-1:0] rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_ovf
`ifdef ALU_ARB_STICKY_OVF_EN
  ,
  input  logic                    ovf_clr,
  output logic [1:0]              ovf_sticky
`endif
);

  arb_state_e              state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [3:0]              opcode_q, opcode_d;
  logic signed [WIDTH-1:0] op1_q, op1_d;
  logic signed [WIDTH-1:0] op2_q, op2_d;
  logic                    id_q, id_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_id_q, rsp_id_d;
  logic signed [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                    rsp_zero_q, rsp_zero_d;
  logic                    rsp_ovf_q, rsp_ovf_d;

  logic                    grant_s;
  logic signed [WIDTH-1:0] alu_result_s;
  logic                    alu_zero_s;
  logic                    alu_ovf_s;

  // The ALU always sees the registered operands; its outputs are sampled in EXEC.
  alu_arbiter_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .opcode     (opcode_q),
    .op1        (op1_q),
    .op2        (op2_q),
    .result     (alu_result_s),
    .equals_zero(alu_zero_s),
    .overflow   (alu_ovf_s)
  );

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    opcode_d     = opcode_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~grant_s;
          req1_ready   = grant_s;
          id_d         = grant_s;
          opcode_d     = grant_s ? req1_opcode : req0_opcode;
          op1_d        = grant_s ? req1_op1    : req0_op1;
          op2_d        = grant_s ? req1_op2    : req0_op2;
          last_grant_d = grant_s;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result_s;
        rsp_zero_d   = alu_zero_s;
        rsp_ovf_d    = alu_ovf_s;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      opcode_q     <= 4'b0000;
      op1_q        <= {WIDTH{1'b0}};
      op2_q        <= {WIDTH{1'b0}};
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {WIDTH{1'b0}};
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;

`ifdef ALU_ARB_STICKY_OVF_EN
  logic [1:0] ovf_sticky_q, ovf_sticky_d;
  logic [1:0] sticky_set_s;

  // Set on an overflowing response handshake; the set term is OR-ed last so it beats a clear.
  always_comb begin
    sticky_set_s = 2'b00;
    if (rsp_valid_q && rsp_ready && rsp_ovf_q) begin
      sticky_set_s[rsp_id_q] = 1'b1;
    end else begin
      sticky_set_s = 2'b00;
    end
    ovf_sticky_d = (ovf_sticky_q & ~{2{ovf_clr}}) | sticky_set_s;
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky_q <= 2'b00;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits, shared with the ALU it drives.
REQ-002 Ports (clock and reset first; name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, reset; synchronous and active-low.
- req0_valid, in, 1, requester 0 has an operation.
- req0_ready, out, 1, requester 0 accepted this cycle.
- req0_opcode, in, 4, requester 0 ALU opcode.
- req0_op1, in, WIDTH signed, requester 0 operand 1.
- req0_op2, in, WIDTH signed, requester 0 operand 2.
- req1_valid / req1_ready / req1_opcode / req1_op1 / req1_op2: same as requester 0, for requester 1.
- rsp_valid, out, 1, response held.
- rsp_ready, in, 1, consumer takes the response.
- rsp_id, out, 1, requester that owns the response.
- rsp_result, out, WIDTH signed, ALU result.
- rsp_zero, out, 1, ALU equals_zero.
- rsp_ovf, out, 1, ALU overflow.

Function
REQ-003 The block SHALL share one ALU instance between two requesters through a 3-state FSM: IDLE, EXEC, RESP.
REQ-004 The block SHALL assert reqN_ready only in IDLE, and only for the granted requester; at most one ready is high per cycle.
REQ-005 Accept: on an IDLE edge with a granted valid, the block SHALL register opcode, op1, op2 and id, then go to EXEC.
REQ-006 EXEC SHALL last exactly one cycle: the block captures ALU result, equals_zero and overflow into the rsp_* registers, sets rsp_valid=1 and goes to RESP.
REQ-007 Latency SHALL be 2 cycles: the edge after acceptance is EXEC, and rsp_valid is visible after the second edge.
REQ-008 In RESP, all rsp_* outputs SHALL stay stable until rsp_valid && rsp_ready.
- On that handshake edge: rsp_valid goes to 0 and the FSM goes to IDLE.
- A new acceptance is possible no earlier than the following edge (throughput 1 operation per 3 cycles).
REQ-009 Arbitration SHALL be round-robin with a last_grant bit:
- Only one requester valid: grant it.
- Both valid: grant the one that is not last_grant.
- last_grant updates only on acceptance.
REQ-010 In IDLE, a requester's valid SHALL NOT be withdrawn or change its payload before ready is seen; this is a protocol requirement on requesters, and the bench checks it.
REQ-011 ALU arithmetic, overflow and zero semantics SHALL pass through unmodified; the block does no width extension.
REQ-012 Requests arriving in EXEC or RESP SHALL wait (ready=0) and SHALL NOT be lost.

Reset
REQ-013 When rst_n=0 at an edge, the block SHALL set: FSM to IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_ovf=0, operand registers=0, and last_grant=1 (requester 0 wins the first tie).
REQ-014 Reset in EXEC or RESP SHALL abort the operation; no response is produced for it.

Configuration
REQ-015 Macro ALU_ARB_STICKY_OVF_EN SHALL control a sticky overflow feature.
- Defined: adds input ovf_clr (1 bit) and output ovf_sticky (2 bits). Bit N sets on a response handshake with rsp_id=N and rsp_ovf=1, and clears on ovf_clr or reset. If set and clear occur on the same edge, set wins.
- Undefined: neither port exists and there is no related logic.

Structure
REQ-016 A shared package SHALL hold the ALU opcode constants (ADD=0000, ADD1=0001, SUB=0010, SUB1=0011, AND=0100, OR=0101, XOR=0110, NAND=0111, SHL1..4=1000..1011, SHR1..4=1100..1111) and the FSM state encoding.
REQ-017 The block SHALL instantiate the existing ALU module once, as its only sub-module, with WIDTH passed through.

Verification (WIDTH=8)
REQ-018 The bench SHALL cover these directed scenarios:
- Requester 0 only, ADD 10,20, rsp_ready=1 → rsp_valid 2 cycles after acceptance with result=30, zero=0, ovf=0, id=0.
- Requester 1 only, ADD 100,100 → result=-56, ovf=1, id=1. With the macro defined: ovf_sticky=2'b10 until ovf_clr.
- Both valid continuously, rsp_ready=1, 4 operations → grant order 0,1,0,1 with no starvation.
- rsp_ready=0 for 5 cycles during RESP with SUB 50,20 → result stays 30 and rsp_valid stays 1; both readys stay 0; pending requests are served after release.
- Reset asserted during EXEC of SUB -128,1 → no response; after release, the first tie is granted to requester 0.
- SUB 5,5 → result=0, zero=1.
